// File: rtl/nanov_pkg.sv
// rtl/nanov_pkg.sv - shared constants and types for the digit-serial execution unit
package nanov_pkg;

   localparam int XLEN_DEF = 32;

   // op = {alt, funct3}; alt selects SUB for ADD and SRA for SRL
   localparam int ALT_BIT = 3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_SLT  = 3'b010;
   localparam logic [2:0] OP_SLTU = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SR   = 3'b101;
   localparam logic [2:0] OP_OR   = 3'b110;
   localparam logic [2:0] OP_AND  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2
   } state_t;

   // Comparisons and shifts need the whole operand before any result digit exists
   function automatic logic is_two_pass(input logic [2:0] f3);
      return (f3 == OP_SLL) || (f3 == OP_SLT) || (f3 == OP_SLTU) || (f3 == OP_SR);
   endfunction

endpackage

// File: rtl/nanov_digit_adder.sv
// rtl/nanov_digit_adder.sv - DIGIT-wide add with carry in/out and nonzero detect
module nanov_digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             nz
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
   assign nz          = |sum;

endmodule

// File: rtl/nanov_digit_exec.sv
// rtl/nanov_digit_exec.sv - digit-serial RV32I/RV64I integer execution unit
module nanov_digit_exec
   import nanov_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [DIGIT-1:0] a_digit,
   input  logic [DIGIT-1:0] b_digit,
   output logic             busy,
   output logic             out_valid,
   output logic [DIGIT-1:0] out_digit,
   output logic             done,
   output logic             zero_flag,
   output logic             lt_flag
);

   localparam int N   = XLEN / DIGIT;
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(N);
   localparam int DSH = $clog2(DIGIT);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [3:0]        op_r;
   logic              carry_r;
   logic [SHW-1:0]    sh_r;
   logic [XLEN-1:0]   sbuf_r;
   logic              zero_r;
   logic              lt_r;

   logic [2:0]        f3;
   logic              last;
   logic              two_pass;
   logic              sub_mode;
   logic              is_addsub;
   logic [DIGIT-1:0]  b_eff;
   logic              cin;
   logic [DIGIT-1:0]  sum;
   logic              cout;
   logic              nz;
   logic              lt_now;
   logic [XLEN-1:0]   shres;
   logic [SHW-1:0]    bit_base;

   assign f3        = op_r[2:0];
   assign last      = (cnt == LAST);
   assign two_pass  = is_two_pass(f3);
   assign is_addsub = (f3 == OP_ADD);
   assign sub_mode  = (is_addsub && op_r[ALT_BIT]) || (f3 == OP_SLT) || (f3 == OP_SLTU);

   // Subtraction is a + ~b + 1, the +1 injected as carry-in on the first digit
   assign b_eff = sub_mode ? ~b_digit : b_digit;
   assign cin   = (cnt == '0) ? sub_mode : carry_r;

   nanov_digit_adder #(.DIGIT(DIGIT)) u_adder (
      .a    (a_digit),
      .b    (b_eff),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .nz   (nz)
   );

   // Unsigned: borrow out of a-b; signed: sign of a when signs differ, else sign of the difference
   assign lt_now = (f3 == OP_SLTU) ? ~cout :
                   ((a_digit[DIGIT-1] ^ b_digit[DIGIT-1]) ? a_digit[DIGIT-1] : sum[DIGIT-1]);

   // The final digit is still combinational at done, so fold it into the reported flags
   assign zero_flag = (state == PASS1 && last && is_addsub) ? (zero_r & ~nz) : zero_r;
   assign lt_flag   = (state == PASS1 && last && sub_mode) ? lt_now : lt_r;

   assign bit_base = SHW'(cnt) << DSH;

   // Full-width shift of the buffered operand; PASS2 picks out one digit per cycle
   always_comb begin
      shres = '0;
      if (f3 == OP_SLL)
         shres = sbuf_r << sh_r;
      else if (f3 == OP_SR)
         shres = op_r[ALT_BIT] ? $unsigned($signed(sbuf_r) >>> sh_r) : (sbuf_r >> sh_r);
   end

   // Result digit select; forced to zero whenever out_valid is low
   always_comb begin
      out_digit = '0;
      if (state == PASS1 && !two_pass) begin
         case (f3)
            OP_ADD:  out_digit = sum;
            OP_XOR:  out_digit = a_digit ^ b_digit;
            OP_OR:   out_digit = a_digit | b_digit;
            OP_AND:  out_digit = a_digit & b_digit;
            default: out_digit = '0;
         endcase
      end else if (state == PASS2) begin
         case (f3)
            OP_SLT, OP_SLTU: out_digit = (cnt == '0) ? DIGIT'(lt_r) : '0;
            OP_SLL, OP_SR:   out_digit = shres[bit_base +: DIGIT];
            default:         out_digit = '0;
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Sequencer next state and handshake outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = PASS1;
         end
         PASS1: begin
            busy      = 1'b1;
            out_valid = !two_pass;
            done      = !two_pass && last;
            if (last)
               state_nxt = two_pass ? PASS2 : IDLE;
         end
         PASS2: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            done      = last;
            if (last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: digit counter, carry, shift buffer, shift amount and flags
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt     <= '0;
         op_r    <= '0;
         carry_r <= 1'b0;
         sh_r    <= '0;
         sbuf_r  <= '0;
         zero_r  <= 1'b0;
         lt_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r    <= op;
                  cnt     <= '0;
                  carry_r <= 1'b0;
                  zero_r  <= 1'b0;
                  lt_r    <= 1'b0;
               end
            end
            PASS1: begin
               cnt     <= last ? '0 : cnt + CW'(1);
               carry_r <= cout;
               sbuf_r  <= {a_digit, sbuf_r[XLEN-1:DIGIT]};
               for (int i = 0; i < SHW; i++) begin
                  if (CW'(i / DIGIT) == cnt)
                     sh_r[i] <= b_digit[i % DIGIT];
               end
               if (is_addsub)
                  zero_r <= (cnt == '0) ? ~nz : (zero_r & ~nz);
               if (last && sub_mode)
                  lt_r <= lt_now;
            end
            PASS2: begin
               cnt <= last ? '0 : cnt + CW'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule
